// File: rtl/alu_pkg.sv
// alu_pkg: shared width and divider state encoding for the 8-bit ALU datapath.
//   ALU_WIDTH   - default operand width
//   div_state_t - divider FSM states
package alu_pkg;
    localparam int ALU_WIDTH = 8;
    typedef enum logic [1:0] {LOAD, CALC, DONE} div_state_t;
endpackage

// File: rtl/divider_if.sv
// divider_if: operand/result bundle of the sequential divider.
//   a, b    - dividend, divisor (driven by master)
//   q, r    - quotient, remainder (driven by slave)
//   done    - result valid for the latched operands (driven by slave)
interface divider_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             done;
    modport master (output a, b, input q, r, done);
    modport slave  (input a, b, output q, r, done);
endinterface

// File: rtl/divider.sv
// divider: restoring shift-subtract unsigned divider, one step per clock,
// restarting automatically whenever the operands differ from the latched ones.
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - divider_if.slave: a, b in; q, r, done out
module divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_l_q, a_l_d, b_l_q, b_l_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   rem_sh, trial, rem_nx;
    logic [WIDTH-1:0] dvd_sh;

    always_comb begin
        // The partial remainder is always below the divisor, so its top bit
        // is free to take the incoming dividend bit; trial's MSB is the borrow.
        rem_sh  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, b_l_q};
        rem_nx  = trial[WIDTH] ? rem_sh : trial;
        dvd_sh  = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        state_d = state_q;
        a_l_d   = a_l_q;
        b_l_d   = b_l_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = done_q;
        if (state_q == LOAD) begin
            a_l_d   = bus.a;
            b_l_d   = bus.b;
            rem_d   = '0;
            dvd_d   = bus.a;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = CALC;
        end else if (state_q == CALC) begin
            rem_d = rem_nx;
            dvd_d = dvd_sh;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                q_d     = dvd_sh;
                r_d     = rem_nx[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = DONE;
            end
        end else if ({bus.a, bus.b} != {a_l_q, b_l_q}) begin
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            a_l_q   <= '0;
            b_l_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_l_q   <= a_l_d;
            b_l_q   <= b_l_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: table-driven and sequence checks of the divider.
module tb_divider;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [11];

    divider_if #(.WIDTH(8)) dif ();
    divider #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(dif.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        edge_n(1);
        rst = 1'b0;
    endtask

    task automatic set_ops(input logic [7:0] a, input logic [7:0] b);
        dif.a = a;
        dif.b = b;
    endtask

    initial begin
        vecs[0]  = '{8'd7,   8'd3,   8'd2,   8'd1};
        vecs[1]  = '{8'd200, 8'd7,   8'd28,  8'd4};
        vecs[2]  = '{8'd255, 8'd255, 8'd1,   8'd0};
        vecs[3]  = '{8'd5,   8'd0,   8'hFF,  8'd5};
        vecs[4]  = '{8'd3,   8'd10,  8'd0,   8'd3};
        vecs[5]  = '{8'd0,   8'd1,   8'd0,   8'd0};
        vecs[6]  = '{8'd100, 8'd9,   8'd11,  8'd1};
        vecs[7]  = '{8'd100, 8'd10,  8'd10,  8'd0};
        vecs[8]  = '{8'd255, 8'd1,   8'd255, 8'd0};
        vecs[9]  = '{8'd128, 8'd16,  8'd8,   8'd0};
        vecs[10] = '{8'd0,   8'd0,   8'hFF,  8'd0};
        set_ops(8'd0, 8'd0);
        edge_n(2);
        rst = 1'b0;
        chk("reset_done", dif.done, 8'd0);
        chk("reset_q", dif.q, 8'd0);
        chk("reset_r", dif.r, 8'd0);

        // Each vector from reset: done only after the 9th edge, outputs zero before.
        foreach (vecs[k]) begin
            do_reset();
            set_ops(vecs[k].a, vecs[k].b);
            edge_n(8);
            chk($sformatf("v%0d_done_e8", k), dif.done, 8'd0);
            chk($sformatf("v%0d_q_e8", k), dif.q, 8'd0);
            edge_n(1);
            chk($sformatf("v%0d_done_e9", k), dif.done, 8'd1);
            chk($sformatf("v%0d_q", k), dif.q, vecs[k].q);
            chk($sformatf("v%0d_r", k), dif.r, vecs[k].r);
        end

        // Operand change while in DONE: 10 edges to the new result.
        do_reset();
        set_ops(8'd200, 8'd7);
        edge_n(10);
        chk("chg_pre_q", dif.q, 8'd28);
        set_ops(8'd255, 8'd255);
        edge_n(1);
        chk("chg_e1_done", dif.done, 8'd1);
        edge_n(1);
        chk("chg_e2_done", dif.done, 8'd0);
        chk("chg_e2_q_held", dif.q, 8'd28);
        chk("chg_e2_r_held", dif.r, 8'd4);
        edge_n(7);
        chk("chg_e9_done", dif.done, 8'd0);
        edge_n(1);
        chk("chg_e10_done", dif.done, 8'd1);
        chk("chg_e10_q", dif.q, 8'd1);
        chk("chg_e10_r", dif.r, 8'd0);

        // Divisor changed mid-run: first result for old operands, then rerun.
        do_reset();
        set_ops(8'd100, 8'd9);
        edge_n(3);
        dif.b = 8'd10;
        edge_n(6);
        chk("mid_e9_done", dif.done, 8'd1);
        chk("mid_e9_q", dif.q, 8'd11);
        chk("mid_e9_r", dif.r, 8'd1);
        edge_n(1);
        chk("mid_e10_done", dif.done, 8'd1);
        edge_n(1);
        chk("mid_e11_done", dif.done, 8'd0);
        chk("mid_e11_q_held", dif.q, 8'd11);
        edge_n(7);
        chk("mid_e18_done", dif.done, 8'd0);
        edge_n(1);
        chk("mid_e19_done", dif.done, 8'd1);
        chk("mid_e19_q", dif.q, 8'd10);
        chk("mid_e19_r", dif.r, 8'd0);

        // Reset mid-run clears held results, then a full fresh run follows.
        do_reset();
        set_ops(8'd200, 8'd7);
        edge_n(10);
        set_ops(8'd255, 8'd255);
        edge_n(4);
        chk("rst_pre_q", dif.q, 8'd28);
        rst = 1'b1;
        edge_n(1);
        chk("rst_q", dif.q, 8'd0);
        chk("rst_r", dif.r, 8'd0);
        chk("rst_done", dif.done, 8'd0);
        rst = 1'b0;
        edge_n(8);
        chk("rst_e8_done", dif.done, 8'd0);
        edge_n(1);
        chk("rst_e9_done", dif.done, 8'd1);
        chk("rst_e9_q", dif.q, 8'd1);
        chk("rst_e9_r", dif.r, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
